// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: imem read port plus the IF output stage handshake toward decode.
// The master modport is the fetch controller; the slave modport is imem/decode (or a bench).
interface fetch_ctrl_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned CLEN = 4;

    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_instr;
    logic            imem_exc_en;
    logic [CLEN-1:0] imem_exc_code;
    logic [XLEN-1:0] imem_exc_val;

    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_exc_en;
    logic [CLEN-1:0] out_exc_code;
    logic [XLEN-1:0] out_exc_val;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  imem_exc_en,
        input  imem_exc_code,
        input  imem_exc_val,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_exc_en,
        output out_exc_code,
        output out_exc_val
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output imem_exc_en,
        output imem_exc_code,
        output imem_exc_val,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_exc_en,
        input  out_exc_code,
        input  out_exc_val
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses imem directly from the PC register and
// registers each fetch into a one-entry output stage; a trapped fetch parks it until a redirect.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    input  logic          redirect_en,
    input  logic [63:0]   redirect_pc,
    fetch_ctrl_if.master  bus,
    output logic [63:0]   fetch_cnt
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned CLEN = 4;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]      state_q,    state_n;
    logic [XLEN-1:0] pc_q,       pc_n;
    logic            valid_q,    valid_n;
    logic [ILEN-1:0] instr_q,    instr_n;
    logic [XLEN-1:0] opc_q,      opc_n;
    logic            exc_en_q,   exc_en_n;
    logic [CLEN-1:0] exc_code_q, exc_code_n;
    logic [XLEN-1:0] exc_val_q,  exc_val_n;
    logic [XLEN-1:0] cnt_q,      cnt_n;

    logic slot_free_c;
    logic xfer_c;
    logic capture_c;

    assign slot_free_c = !valid_q || bus.out_ready;
    assign xfer_c      = valid_q && bus.out_ready;
    assign capture_c   = (state_q == ST_FETCH) && fetch_en && slot_free_c;

    // imem sees the PC register with no logic in between
    assign bus.imem_addr    = pc_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_pc       = opc_q;
    assign bus.out_exc_en   = exc_en_q;
    assign bus.out_exc_code = exc_code_q;
    assign bus.out_exc_val  = exc_val_q;
    assign fetch_cnt        = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            opc_q      <= '0;
            exc_en_q   <= 1'b0;
            exc_code_q <= '0;
            exc_val_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            valid_q    <= valid_n;
            instr_q    <= instr_n;
            opc_q      <= opc_n;
            exc_en_q   <= exc_en_n;
            exc_code_q <= exc_code_n;
            exc_val_q  <= exc_val_n;
            cnt_q      <= cnt_n;
        end
    end

    // Redirect beats capture beats a bare transfer; anything else holds.
    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        valid_n    = valid_q;
        instr_n    = instr_q;
        opc_n      = opc_q;
        exc_en_n   = exc_en_q;
        exc_code_n = exc_code_q;
        exc_val_n  = exc_val_q;
        cnt_n      = cnt_q + XLEN'(xfer_c);

        if (redirect_en) begin
            pc_n    = redirect_pc;
            valid_n = 1'b0;
            state_n = ST_FETCH;
        end else if (capture_c) begin
            valid_n = 1'b1;
            opc_n   = pc_q;
            if (pc_q[1:0] != 2'b00) begin
                // misaligned PC traps before imem's own fault is considered
                instr_n    = NOP_INSTR;
                exc_en_n   = 1'b1;
                exc_code_n = '0;
                exc_val_n  = pc_q;
                state_n    = ST_FAULT;
            end else if (bus.imem_exc_en) begin
                instr_n    = NOP_INSTR;
                exc_en_n   = 1'b1;
                exc_code_n = bus.imem_exc_code;
                exc_val_n  = bus.imem_exc_val;
                state_n    = ST_FAULT;
            end else begin
                instr_n    = bus.imem_instr;
                exc_en_n   = 1'b0;
                exc_code_n = '0;
                exc_val_n  = '0;
                pc_n       = pc_q + XLEN'(4);
            end
        end else if (xfer_c) begin
            valid_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a transaction-level model predicts each fetched entry,
// and a negedge monitor compares whatever the output stage presents against it.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned MEM_WORDS = 4096;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic [63:0] fetch_cnt;

    fetch_ctrl_if bus_if ();

    fetch_ctrl #(.RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .bus         (bus_if),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MEM_WORDS];

    // low 16 KiB is backed; a small window at the top of the space aliases it so wrap can be seen
    function automatic bit in_range(input logic [63:0] a);
        return (a < 64'h4000) || (a >= 64'hFFFF_FFFF_FFFF_FF00);
    endfunction

    function automatic logic [3:0] fault_code(input logic [63:0] a);
        return (a >= 64'h80000 && a < 64'hFFFF_FFFF_FFFF_FF00) ? 4'd5 : 4'd1;
    endfunction

    always_comb begin
        bus_if.imem_instr    = mem[bus_if.imem_addr[13:2]];
        bus_if.imem_exc_en   = !in_range(bus_if.imem_addr);
        bus_if.imem_exc_code = fault_code(bus_if.imem_addr);
        bus_if.imem_exc_val  = bus_if.imem_addr;
    end

    int unsigned checks = 0;
    int unsigned passed = 0;
    bit          mon_en = 1'b0;

    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    bit          m_fault;
    bit          m_held;
    entry_t      exp_q [$];

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_pc    = 64'h0;
        m_cnt   = 64'h0;
        m_fault = 1'b0;
        m_held  = 1'b0;
        exp_q.delete();
    endtask

    // reference model: what a fetch at a given PC must produce
    function automatic entry_t predict(input logic [63:0] pc);
        entry_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.instr = NOP; e.exc_en = 1'b1; e.code = 4'd0; e.val = pc;
        end else if (!in_range(pc)) begin
            e.instr = NOP; e.exc_en = 1'b1; e.code = fault_code(pc); e.val = pc;
        end else begin
            e.instr = mem[pc[13:2]]; e.exc_en = 1'b0; e.code = 4'd0; e.val = 64'h0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            bit xfer;
            entry_t e;
            xfer = m_held && bus_if.out_ready;
            if (xfer) m_cnt = m_cnt + 64'd1;
            if (redirect_en) begin
                if (m_held && !bus_if.out_ready && exp_q.size() != 0) void'(exp_q.pop_back());
                m_pc    = redirect_pc;
                m_fault = 1'b0;
                m_held  = 1'b0;
            end else if (!m_fault && fetch_en && (!m_held || bus_if.out_ready)) begin
                e = predict(m_pc);
                exp_q.push_back(e);
                m_held = 1'b1;
                if (e.exc_en) m_fault = 1'b1;
                else m_pc = m_pc + 64'd4;
            end else if (xfer) begin
                m_held = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check64("out_valid", 64'(bus_if.out_valid), 64'(m_held));
            check64("imem_addr", bus_if.imem_addr, m_pc);
            check64("fetch_cnt", fetch_cnt, m_cnt);
            if (bus_if.out_valid) begin
                check64("entry_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check64("out_pc",       bus_if.out_pc,             exp_q[0].pc);
                    check64("out_instr",    64'(bus_if.out_instr),     64'(exp_q[0].instr));
                    check64("out_exc_en",   64'(bus_if.out_exc_en),    64'(exp_q[0].exc_en));
                    check64("out_exc_code", 64'(bus_if.out_exc_code),  64'(exp_q[0].code));
                    check64("out_exc_val",  bus_if.out_exc_val,        exp_q[0].val);
                    if (bus_if.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] a);
        redirect_en = 1'b1;
        redirect_pc = a;
        step();
        redirect_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check64({tag, "_valid"},    64'(bus_if.out_valid),    64'd0);
        check64({tag, "_instr"},    64'(bus_if.out_instr),    64'(NOP));
        check64({tag, "_pc"},       bus_if.out_pc,            64'd0);
        check64({tag, "_exc_en"},   64'(bus_if.out_exc_en),   64'd0);
        check64({tag, "_exc_code"}, 64'(bus_if.out_exc_code), 64'd0);
        check64({tag, "_exc_val"},  bus_if.out_exc_val,       64'd0);
        check64({tag, "_cnt"},      fetch_cnt,                64'd0);
        check64({tag, "_addr"},     bus_if.imem_addr,         64'd0);
    endtask

    function automatic logic [63:0] pick_target();
        case ($urandom_range(0, 6))
            0: return 64'({$urandom_range(0, MEM_WORDS - 1), 2'b00});
            1: return 64'({$urandom_range(0, MEM_WORDS - 1), 2'b00}) | 64'($urandom_range(1, 3));
            2: return 64'h40000;
            3: return 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
            4: return 64'h0;
            5: return 64'h40002;
            default: return 64'h80000;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 64'h0;
        bus_if.out_ready = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // streaming from reset, one per cycle
        fetch_en = 1'b1;
        bus_if.out_ready = 1'b1;
        repeat (6) step();

        // decode stall then release
        bus_if.out_ready = 1'b0;
        repeat (3) step();
        bus_if.out_ready = 1'b1;
        repeat (3) step();

        // imem access fault, parked until redirect
        redirect(64'h40000);
        repeat (5) step();
        redirect(64'h0);
        repeat (4) step();

        // misaligned, and misaligned winning over an imem fault
        redirect(64'h6);
        repeat (4) step();
        redirect(64'h40002);
        repeat (3) step();

        // PC wraps through zero
        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        repeat (6) step();

        // redirect flushes a stalled entry, and wins over a capture
        bus_if.out_ready = 1'b0;
        repeat (2) step();
        redirect(64'h100);
        redirect(64'h200);
        repeat (2) step();
        bus_if.out_ready = 1'b1;
        repeat (3) step();

        // fetch_en low still lets a held entry drain
        bus_if.out_ready = 1'b0;
        step();
        fetch_en = 1'b0;
        step();
        bus_if.out_ready = 1'b1;
        repeat (3) step();
        fetch_en = 1'b1;
        repeat (2) step();

        // async reset while stalled in a trapped fetch
        redirect(64'h40000);
        bus_if.out_ready = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midreset");
        step();
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        repeat (4) step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            fetch_en         = ($urandom_range(0, 9) < 8);
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            redirect_en      = ($urandom_range(0, 99) < 6);
            redirect_pc      = pick_target();
            step();
        end
        redirect_en = 1'b0;
        fetch_en = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (3) step();
        check64("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
